// File: rtl/axi_slave_ram_if.sv
// axi_slave_ram_if: AXI4 write/read burst channels between a burst master and the RAM target.
interface axi_slave_ram_if #(
    parameter int DATA_W = 16
);
    logic              awvalid;
    logic              awready;
    logic [24:0]       awaddr;
    logic [7:0]        awlen;
    logic              wvalid;
    logic              wready;
    logic [DATA_W-1:0] wdata;
    logic              wlast;
    logic              bvalid;
    logic              bready;
    logic [1:0]        bresp;
    logic              arvalid;
    logic              arready;
    logic [24:0]       araddr;
    logic [7:0]        arlen;
    logic              rvalid;
    logic              rready;
    logic [DATA_W-1:0] rdata;
    logic [1:0]        rresp;
    logic              rlast;

    modport slave (
        input  awvalid, awaddr, awlen, wvalid, wdata, wlast, bready,
               arvalid, araddr, arlen, rready,
        output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp, rlast
    );

    modport master (
        output awvalid, awaddr, awlen, wvalid, wdata, wlast, bready,
               arvalid, araddr, arlen, rready,
        input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp, rlast
    );
endinterface

// File: rtl/axi_slave_ram.sv
// axi_slave_ram: AXI4 INCR burst responder backed by a 2^ADDR_W x 16-bit block RAM.
module axi_slave_ram #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 16
) (
    input logic            clk,
    input logic            reset_n,
    axi_slave_ram_if.slave bus
);
    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
    typedef enum logic [1:0] {R_IDLE, R_ADDR, R_FETCH, R_DATA} r_state_t;

    w_state_t w_state, w_next;
    r_state_t r_state, r_next;
    logic [DATA_W-1:0] mem [2**ADDR_W];
    logic [ADDR_W-1:0] w_addr, r_addr;
    logic [7:0] w_len, w_cnt, r_len, r_cnt;
    logic w_err;
    logic aw_hs, w_hs, b_hs, ar_hs, r_hs, w_end, r_end;

    assign aw_hs = bus.awvalid && bus.awready;
    assign w_hs  = bus.wvalid && bus.wready;
    assign b_hs  = bus.bvalid && bus.bready;
    assign ar_hs = bus.arvalid && bus.arready;
    assign r_hs  = bus.rvalid && bus.rready;
    assign w_end = w_cnt == w_len;
    assign r_end = r_cnt == r_len;

    assign bus.bresp = {bus.bvalid && w_err, 1'b0};
    assign bus.rresp = 2'b00;
    assign bus.rlast = bus.rvalid && r_end;

    // Only the beat count terminates a write burst; wlast merely feeds the error flag.
    always_comb begin
        w_next = aw_hs ? W_DATA : (w_hs && w_end) ? W_RESP : b_hs ? W_IDLE : w_state;
        r_next = ar_hs ? R_ADDR : (r_state == R_ADDR) ? R_FETCH : (r_state == R_FETCH) ? R_DATA :
                 (r_hs && r_end) ? R_IDLE : r_state;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            w_state     <= W_IDLE;
            r_state     <= R_IDLE;
            bus.awready <= 1'b0;
            bus.wready  <= 1'b0;
            bus.bvalid  <= 1'b0;
            bus.arready <= 1'b0;
            bus.rvalid  <= 1'b0;
            bus.rdata   <= '0;
            w_addr      <= '0;
            w_len       <= '0;
            w_cnt       <= '0;
            w_err       <= 1'b0;
            r_addr      <= '0;
            r_len       <= '0;
            r_cnt       <= '0;
        end else begin
            w_state     <= w_next;
            r_state     <= r_next;
            bus.awready <= w_next == W_IDLE;
            bus.wready  <= w_next == W_DATA;
            bus.bvalid  <= w_next == W_RESP;
            bus.arready <= r_next == R_IDLE;
            bus.rvalid  <= r_next == R_DATA;
            if (aw_hs) begin
                w_addr <= bus.awaddr[ADDR_W-1:0];
                w_len  <= bus.awlen;
                w_cnt  <= '0;
                w_err  <= 1'b0;
            end
            if (w_hs) begin
                w_addr <= w_addr + 1'b1;
                w_cnt  <= w_cnt + 8'd1;
                if (bus.wlast != w_end) w_err <= 1'b1;
            end
            if (ar_hs) begin
                r_addr <= bus.araddr[ADDR_W-1:0];
                r_len  <= bus.arlen;
                r_cnt  <= '0;
            end
            // rdata only advances on fetch or an accepted beat, so it holds while stalled.
            if (r_state == R_FETCH || (r_hs && !r_end)) begin
                bus.rdata <= mem[r_addr];
                r_addr    <= r_addr + 1'b1;
            end
            if (r_hs) r_cnt <= r_cnt + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_hs) mem[w_addr] <= bus.wdata;
    end
endmodule

// File: tb/tb_axi_slave_ram.sv
// tb_axi_slave_ram: randomized scoreboard bench for axi_slave_ram against an array memory model.
module tb_axi_slave_ram;
    localparam int DEPTH = 1024;

    logic clk;
    logic reset_n;
    axi_slave_ram_if #(.DATA_W(16)) bus ();

    axi_slave_ram #(.ADDR_W(10), .DATA_W(16)) dut (
        .clk(clk),
        .reset_n(reset_n),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors = 0;
    int errors = 0;
    logic [15:0] ref_mem [DEPTH];
    logic [16:0] exp_r [$];
    logic [1:0]  exp_b [$];
    logic        stall_prev = 1'b0;
    logic [16:0] prev_r;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic logic [31:0] outs();
        return {6'd0, bus.awready, bus.wready, bus.bvalid, bus.bresp, bus.arready,
                bus.rvalid, bus.rdata, bus.rresp, bus.rlast};
    endfunction

    // Monitor: pops the scoreboard whenever a handshake is about to happen.
    always @(negedge clk) begin
        if (!reset_n) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) chk("r_stall_hold", {bus.rvalid, bus.rlast, bus.rdata}, {1'b1, prev_r});
            if (bus.rvalid && bus.rready) begin
                if (exp_r.size() == 0) chk("r_unexpected_beat", {bus.rlast, bus.rdata}, 32'hFFFF_FFFF);
                else chk("r_beat", {bus.rlast, bus.rdata}, exp_r.pop_front());
            end
            stall_prev = bus.rvalid && !bus.rready;
            prev_r = {bus.rlast, bus.rdata};
            if (bus.bvalid && bus.bready) begin
                if (exp_b.size() == 0) chk("b_unexpected", bus.bresp, 32'hFFFF_FFFF);
                else chk("b_resp", bus.bresp, exp_b.pop_front());
            end
        end
    end

    task automatic write_burst(input int addr, input int len, input int err_beat,
                               input int bready_wait, input int abort_at, input int dbase);
        logic [15:0] d;
        int n;
        if (abort_at < 0) exp_b.push_back((err_beat >= 0 && err_beat != len) ? 2'b10 : 2'b00);
        @(posedge clk);
        #1;
        bus.awvalid = 1'b1;
        bus.awaddr = 25'(addr);
        bus.awlen = 8'(len);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.awready && n < 200);
        chk("aw_accept", bus.awready, 1);
        @(posedge clk);
        #1 bus.awvalid = 1'b0;
        for (int i = 0; i <= len; i++) begin
            if (i == abort_at) begin
                reset_n = 1'b0;
                bus.wvalid = 1'b0;
                bus.wlast = 1'b0;
                @(negedge clk);
                chk("mid_reset_outs", outs(), 0);
                @(posedge clk);
                #1 reset_n = 1'b1;
                return;
            end
            d = (dbase < 0) ? 16'($urandom) : 16'(dbase + i);
            bus.wvalid = 1'b1;
            bus.wdata = d;
            bus.wlast = (err_beat >= 0) ? (i == err_beat) : (i == len);
            @(negedge clk);
            chk("wready", bus.wready, 1);
            @(posedge clk);
            #1 ref_mem[(addr + i) % DEPTH] = d;
        end
        bus.wvalid = 1'b0;
        bus.wlast = 1'b0;
        @(negedge clk);
        chk("b_latency", {bus.bvalid, bus.wready}, 2'b10);
        for (int i = 0; i < bready_wait; i++) begin
            chk("b_hold", {bus.bvalid, bus.awready}, 2'b10);
            @(negedge clk);
        end
        @(posedge clk);
        #1 bus.bready = 1'b1;
        @(negedge clk);
        @(posedge clk);
        #1 bus.bready = 1'b0;
        @(negedge clk);
        chk("aw_return", {bus.bvalid, bus.awready}, 2'b01);
    endtask

    // mode 0: rready always high, 1: pattern 1,0,0,1,1,0,1 once data flows, 2: random.
    task automatic read_burst(input int addr, input int len, input int mode);
        logic [6:0] pat = 7'b1001101;
        int n, got, k, first;
        for (int i = 0; i <= len; i++) exp_r.push_back({i == len, ref_mem[(addr + i) % DEPTH]});
        @(posedge clk);
        #1;
        bus.arvalid = 1'b1;
        bus.araddr = 25'(addr);
        bus.arlen = 8'(len);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.arready && n < 200);
        chk("ar_accept", bus.arready, 1);
        @(posedge clk);
        #1 bus.arvalid = 1'b0;
        got = 0;
        k = 0;
        first = -1;
        while (got <= len && k < 2000) begin
            bus.rready = (mode == 0) ? 1'b1 : (mode == 1) ? pat[6 - ((k < 2) ? 0 : (k - 2) % 7)] :
                         1'($urandom_range(0, 1));
            @(negedge clk);
            if (bus.rvalid && first < 0) first = k;
            if (bus.rvalid && bus.rready) got++;
            k++;
            @(posedge clk);
            #1;
        end
        bus.rready = 1'b0;
        chk("r_latency", first, 2);
        chk("r_beat_count", got, len + 1);
        @(negedge clk);
        chk("r_end", {bus.rvalid, bus.arready}, 2'b01);
        chk("r_sb_drained", exp_r.size(), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int a, l, e;
        reset_n = 1'b0;
        {bus.awvalid, bus.wvalid, bus.wlast, bus.bready, bus.arvalid, bus.rready} = '0;
        bus.awaddr = '0;
        bus.awlen = '0;
        bus.wdata = '0;
        bus.araddr = '0;
        bus.arlen = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_outs", outs(), 0);
        reset_n = 1'b1;
        #1 chk("ready_before_edge", {bus.awready, bus.arready}, 2'b00);
        @(negedge clk);
        chk("ready_after_edge", {bus.awready, bus.arready}, 2'b11);

        for (int b = 0; b < 4; b++) write_burst(b * 256, 255, -1, 0, -1, -1);

        write_burst(16, 3, -1, 0, -1, 'hA000);
        read_burst(16, 3, 0);
        read_burst(16, 3, 1);

        write_burst(32, 2, 1, 5, -1, -1);
        read_burst(32, 2, 2);

        // AR handshake one edge after AW so the read samples word 0 as beat 2 writes it.
        fork
            write_burst(1022, 3, -1, 0, -1, 'hC000);
            begin
                @(posedge clk);
                read_burst(0, 0, 0);
            end
        join
        read_burst(1022, 3, 0);

        write_burst(100, 3, -1, 0, 2, 'hD000);
        repeat (5) begin
            @(negedge clk);
            chk("abort_no_b", bus.bvalid, 0);
        end
        write_burst(200, 1, -1, 0, -1, -1);
        read_burst(100, 3, 0);

        repeat (30) begin
            a = int'($urandom_range(0, 32'h1FF_FFFF));
            l = int'($urandom_range(0, 15));
            e = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, l)) : -1;
            write_burst(a, l, e, int'($urandom_range(0, 3)), -1, -1);
            a = int'($urandom_range(0, 32'h1FF_FFFF));
            read_burst(a, int'($urandom_range(0, 15)), 2);
        end

        repeat (5) @(negedge clk);
        chk("b_sb_drained", exp_b.size(), 0);
        chk("r_sb_final", exp_r.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
